// File: rtl/master_comm_rx_if.sv
// Message-link receive bundle: serial FSX/RXD in from the slave serializer,
// byte stream and end-of-frame status out to the master's message parser.
interface master_comm_rx_if;
  logic        msg_fsx_i;
  logic        msg_rxd_i;
  logic        rx_data_vld_o;
  logic [7:0]  rx_data_o;
  logic        rx_frame_done_o;
  logic [15:0] rx_byte_num_o;
  logic        rx_crc_err_o;
  logic        rx_ovf_o;

  // master: the receiver block itself
  modport master (
    input  msg_fsx_i, msg_rxd_i,
    output rx_data_vld_o, rx_data_o, rx_frame_done_o,
           rx_byte_num_o, rx_crc_err_o, rx_ovf_o
  );

  // slave: the link driver / byte consumer facing the receiver
  modport slave (
    output msg_fsx_i, msg_rxd_i,
    input  rx_data_vld_o, rx_data_o, rx_frame_done_o,
           rx_byte_num_o, rx_crc_err_o, rx_ovf_o
  );
endinterface

// File: rtl/master_comm_rx.sv
// Serial message receiver: deserializes FSX-framed MSB-first bytes, emits payload
// bytes, and checks the trailing CRC-8 (x^8+x^2+x+1) at end of frame.
module master_comm_rx #(
  parameter logic [15:0] MAX_BYTES = 16'd1024,
  parameter logic [7:0]  CRC_INIT  = 8'hFF
) (
  input  logic          clk_sys_i,
  input  logic          rst_i,
  master_comm_rx_if.master bus
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

  function automatic logic [7:0] next_crc8_d8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Input stage is deliberately not reset: fsx_d must track a level-high FSX
  // through reset so that it is not mistaken for a rising edge afterwards.
  logic fsx_r_q, fsx_d_q, rxd_r_q;

  always_ff @(posedge clk_sys_i) begin
    fsx_r_q <= bus.msg_fsx_i;
    rxd_r_q <= bus.msg_rxd_i;
    fsx_d_q <= fsx_r_q;
  end

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  hold_byte_q, hold_byte_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  crc_q, crc_d;
  logic        ovf_q, ovf_d;
  logic        emit_vld_q, emit_vld_d;
  logic [7:0]  emit_byte_q, emit_byte_d;
  logic        data_vld_q, data_vld_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] byte_num_q, byte_num_d;
  logic        crc_err_q, crc_err_d;
  logic        ovf_out_q, ovf_out_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    hold_byte_d = hold_byte_q;
    hold_vld_d  = hold_vld_q;
    crc_d       = crc_q;
    ovf_d       = ovf_q;
    emit_vld_d  = 1'b0;
    emit_byte_d = emit_byte_q;
    data_vld_d  = emit_vld_q;
    data_d      = emit_byte_q;
    done_d      = 1'b0;
    byte_num_d  = byte_num_q;
    crc_err_d   = crc_err_q;
    ovf_out_d   = ovf_out_q;

    case (state_q)
      // DONE reports the finished frame and also performs IDLE's edge
      // detection, so a frame starting one cycle after FSX falls is not lost.
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_d     = 1'b1;
          byte_num_d = byte_cnt_q;
          ovf_out_d  = ovf_q;
          crc_err_d  = ovf_q | ~hold_vld_q | (crc_q != hold_byte_q);
        end
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        hold_vld_d = 1'b0;
        ovf_d      = 1'b0;
        crc_d      = CRC_INIT;
        state_d    = IDLE;
        if (fsx_r_q && !fsx_d_q) begin
          state_d   = RECV;
          shift_d   = {shift_q[6:0], rxd_r_q};
          bit_cnt_d = 3'd1;
        end
      end

      RECV: begin
        if (fsx_r_q) begin
          shift_d   = {shift_q[6:0], rxd_r_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          // Each completed byte is held back one byte so the CRC byte,
          // the last complete one, is never emitted as payload.
          if (bit_cnt_q == 3'd7) begin
            if (hold_vld_q) begin
              if (byte_cnt_q == MAX_BYTES) begin
                ovf_d   = 1'b1;
                state_d = DROP;
              end else begin
                emit_vld_d  = 1'b1;
                emit_byte_d = hold_byte_q;
                crc_d       = next_crc8_d8(hold_byte_q, crc_q);
                byte_cnt_d  = byte_cnt_q + 16'd1;
              end
            end
            hold_byte_d = shift_d;
            hold_vld_d  = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end

      DROP: begin
        if (!fsx_r_q) state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      hold_byte_q <= '0;
      hold_vld_q  <= 1'b0;
      crc_q       <= CRC_INIT;
      ovf_q       <= 1'b0;
      emit_vld_q  <= 1'b0;
      emit_byte_q <= '0;
      data_vld_q  <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      byte_num_q  <= '0;
      crc_err_q   <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      hold_byte_q <= hold_byte_d;
      hold_vld_q  <= hold_vld_d;
      crc_q       <= crc_d;
      ovf_q       <= ovf_d;
      emit_vld_q  <= emit_vld_d;
      emit_byte_q <= emit_byte_d;
      data_vld_q  <= data_vld_d;
      data_q      <= data_d;
      done_q      <= done_d;
      byte_num_q  <= byte_num_d;
      crc_err_q   <= crc_err_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign bus.rx_data_vld_o   = data_vld_q;
  assign bus.rx_data_o       = data_q;
  assign bus.rx_frame_done_o = done_q;
  assign bus.rx_byte_num_o   = byte_num_q;
  assign bus.rx_crc_err_o    = crc_err_q;
  assign bus.rx_ovf_o        = ovf_out_q;

endmodule

// File: tb/tb_master_comm_rx.sv
// Directed bench for master_comm_rx: frames driven bit-serially on the falling
// edge, received bytes and frame reports logged and compared to hand-derived values.
module tb_master_comm_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  master_comm_rx_if bus ();

  master_comm_rx #(.MAX_BYTES(16'd4), .CRC_INIT(8'hFF)) dut (
    .clk_sys_i (clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  typedef struct {
    int   num;
    logic err;
    logic ovf;
    int   cyc;
  } done_t;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         overlap_cnt = 0;
  int         start_cyc = 0;
  logic [7:0] vq[$];
  int         vcyc[$];
  done_t      dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_data_vld_o) begin
        vq.push_back(bus.rx_data_o);
        vcyc.push_back(cyc);
      end
      if (bus.rx_frame_done_o)
        dq.push_back('{num: int'(bus.rx_byte_num_o), err: bus.rx_crc_err_o,
                       ovf: bus.rx_ovf_o, cyc: cyc});
      if (bus.rx_data_vld_o && bus.rx_frame_done_o) overlap_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    vq.delete();
    vcyc.delete();
    dq.delete();
  endtask

  // bits are right-justified, sent MSB first; FSX drops the cycle after.
  task automatic send_frame(input logic [63:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      if (i == nbits - 1) start_cyc = cyc + 1;
      bus.msg_fsx_i = 1'b1;
      bus.msg_rxd_i = bits[i];
    end
    @(negedge clk);
    bus.msg_fsx_i = 1'b0;
    bus.msg_rxd_i = 1'b0;
  endtask

  // exp_bytes[31:24] is the first expected byte
  task automatic expect_bytes(input string tag, input int n, input logic [31:0] exp_bytes);
    check_eq({tag, "_nbytes"}, 32'(vq.size()), 32'(n));
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < vq.size()) ? {24'b0, vq[i]} : 32'hDEAD,
               (exp_bytes >> (8 * (3 - i))) & 32'hFF);
  endtask

  task automatic expect_done(input string tag, input int idx, input int num,
                             input logic err, input logic ovf);
    logic [31:0] gn, ge, go;
    if (idx < dq.size()) begin
      gn = 32'(dq[idx].num);
      ge = {31'b0, dq[idx].err};
      go = {31'b0, dq[idx].ovf};
    end else begin
      gn = 32'hDEAD; ge = 32'hDEAD; go = 32'hDEAD;
    end
    check_eq({tag, "_byte_num"}, gn, 32'(num));
    check_eq({tag, "_crc_err"}, ge, {31'b0, err});
    check_eq({tag, "_ovf"}, go, {31'b0, ovf});
  endtask

  initial begin
    bus.msg_fsx_i = 1'b0;
    bus.msg_rxd_i = 1'b0;
    rst = 1'b1;
    idle(4);
    check_eq("rst_vld",      {31'b0, bus.rx_data_vld_o}, 32'h0);
    check_eq("rst_data",     {24'b0, bus.rx_data_o}, 32'h0);
    check_eq("rst_done",     {31'b0, bus.rx_frame_done_o}, 32'h0);
    check_eq("rst_byte_num", {16'b0, bus.rx_byte_num_o}, 32'h0);
    check_eq("rst_crc_err",  {31'b0, bus.rx_crc_err_o}, 32'h0);
    check_eq("rst_ovf",      {31'b0, bus.rx_ovf_o}, 32'h0);
    rst = 1'b0;
    idle(3);

    // single payload byte 0x00, CRC 0xF3
    clear_log();
    send_frame(64'h00F3, 16);
    idle(6);
    check_eq("single_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("single", 1, 32'h0000_0000);
    expect_done("single", 0, 1, 1'b0, 1'b0);
    check_eq("single_byte_latency", (vcyc.size() > 0) ? 32'(vcyc[0] - start_cyc) : 32'hDEAD, 32'd17);
    check_eq("single_done_latency", (dq.size() > 0) ? 32'(dq[0].cyc - start_cyc) : 32'hDEAD, 32'd18);

    // zero payload: lone CRC byte equal to the seed
    clear_log();
    send_frame(64'hFF, 8);
    idle(6);
    check_eq("zero_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("zero", 0, 32'h0);
    expect_done("zero", 0, 0, 1'b0, 1'b0);

    // corrupted CRC
    clear_log();
    send_frame(64'h00F2, 16);
    idle(6);
    check_eq("badcrc_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("badcrc", 1, 32'h0000_0000);
    expect_done("badcrc", 0, 1, 1'b1, 1'b0);

    // FSX high for only 5 bits
    clear_log();
    send_frame(64'h16, 5);
    idle(6);
    check_eq("short_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("short", 0, 32'h0);
    expect_done("short", 0, 0, 1'b1, 1'b0);

    // valid frame plus 3 trailing bits
    clear_log();
    send_frame(64'({16'h00F3, 3'b101}), 19);
    idle(6);
    check_eq("partial_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("partial", 1, 32'h0000_0000);
    expect_done("partial", 0, 1, 1'b0, 1'b0);

    // exactly MAX_BYTES payload, CRC(00 00 00 00) = 0xD1
    clear_log();
    send_frame(64'h00_0000_00D1, 40);
    idle(6);
    check_eq("full_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("full", 4, 32'h0000_0000);
    expect_done("full", 0, 4, 1'b0, 1'b0);
    check_eq("full_spacing", (vcyc.size() > 3) ? 32'(vcyc[3] - vcyc[0]) : 32'hDEAD, 32'd24);

    // six payload bytes against MAX_BYTES = 4
    clear_log();
    send_frame(64'h0011_2233_4455_6677, 56);
    idle(6);
    check_eq("ovf_ndone", 32'(dq.size()), 32'd1);
    expect_bytes("ovf", 4, 32'h1122_3344);
    expect_done("ovf", 0, 4, 1'b1, 1'b1);
    check_eq("ovf_spacing", (vcyc.size() > 3) ? 32'(vcyc[3] - vcyc[0]) : 32'hDEAD, 32'd24);

    // reset mid-frame, FSX held high across reset release
    clear_log();
    for (int i = 11; i >= 0; i--) begin
      @(negedge clk);
      bus.msg_fsx_i = 1'b1;
      bus.msg_rxd_i = i[0];
    end
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_crc_err", {31'b0, bus.rx_crc_err_o}, 32'h0);
    check_eq("rstmid_ovf",     {31'b0, bus.rx_ovf_o}, 32'h0);
    check_eq("rstmid_byte_num", {16'b0, bus.rx_byte_num_o}, 32'h0);
    idle(10);
    bus.msg_fsx_i = 1'b0;
    idle(8);
    check_eq("rstmid_ndone", 32'(dq.size()), 32'd0);
    check_eq("rstmid_nbytes", 32'(vq.size()), 32'd0);

    // back-to-back frames with a one-cycle FSX gap; CRC(12 34) = 0x26
    clear_log();
    send_frame(64'h00F3, 16);
    send_frame(64'h12_3426, 24);
    idle(6);
    check_eq("b2b_ndone", 32'(dq.size()), 32'd2);
    expect_bytes("b2b", 3, 32'h0012_3400);
    expect_done("b2b_a", 0, 1, 1'b0, 1'b0);
    expect_done("b2b_b", 1, 2, 1'b0, 1'b0);

    check_eq("vld_done_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/master_comm_rx.md
# master_comm_rx

Serial message receiver that terminates the slave message link (FSX frame strobe plus serial data, one bit per clock, MSB first) and rebuilds the byte stream. Each frame is N payload bytes followed by one CRC-8 byte. The block delivers payload bytes on a byte-wide valid strobe, then reports byte count, CRC status and overflow at end of frame. It sits on the master side of the message link, directly downstream of the slave serializer, and feeds the master's message parser.

## Interface
- MAX_BYTES, 16'd1024: maximum payload bytes per frame, CRC byte excluded.
- CRC_INIT, 8'hFF: CRC-8 seed loaded at the start of every frame.
- clk_sys_i  in  1: message bit clock. This is the same clock forwarded to the slave as its message clock. The slave launches data on the falling edge; this block samples on the rising edge.
- rst_i  in  1: synchronous, active-high reset.
- msg_fsx_i  in  1: frame strobe; high while frame bits are on the line.
- msg_rxd_i  in  1: serial data, MSB of each byte first.
- rx_data_vld_o  out  1: one-cycle strobe, one per payload byte.
- rx_data_o  out  8: payload byte; valid only while rx_data_vld_o is high.
- rx_frame_done_o  out  1: one-cycle strobe at end of frame.
- rx_byte_num_o  out  16: payload byte count of the last frame.
- rx_crc_err_o  out  1: CRC or format error for the last frame.
- rx_ovf_o  out  1: the last frame exceeded MAX_BYTES.

## Operation
- **Input stage.** msg_fsx_i and msg_rxd_i are registered once into fsx_r and rxd_r. fsx_d is a further delayed copy of fsx_r, used for edge detection. All logic below uses only the registered copies.
- **FSM states:** IDLE, RECV, DROP, DONE.
- **IDLE:**
  - Clear bit_cnt, byte_cnt, hold_vld and the overflow flag; set crc to CRC_INIT.
  - On fsx_r & ~fsx_d (rising edge), go to RECV and capture rxd_r as bit 7 of the first byte.
  - A level-high FSX without a rising edge is ignored. Example: FSX already high when reset releases.
- **RECV, each cycle with fsx_r = 1:**
  - Update shift_reg <= {shift_reg[6:0], rxd_r} and increment bit_cnt (3-bit, wraps 7 -> 0).
  - A byte completes when bit_cnt == 7.
- **On byte completion in RECV:**
  - If hold_vld = 1: output hold_byte on rx_data_o with rx_data_vld_o = 1, set crc <= nextCRC8D8(hold_byte, crc), and increment byte_cnt.
  - In all cases: hold_byte <= completed byte, hold_vld <= 1.
  - The one-byte hold exists because the final complete byte of a frame is the CRC and must never be emitted.
- **Overflow:** if a byte would be emitted while byte_cnt == MAX_BYTES, the byte is not emitted, the overflow flag is set, and the FSM goes to DROP.
- **DROP:** discard all bits until fsx_r = 0, then go to DONE.
- **End of frame:** RECV with fsx_r = 0 goes to DONE. A trailing partial byte (bit_cnt != 0) is discarded silently.
- **DONE (one cycle), then IDLE:**
  - Pulse rx_frame_done_o.
  - Set rx_byte_num_o <= byte_cnt.
  - Set rx_ovf_o <= overflow flag.
  - Set rx_crc_err_o <= ovf | ~hold_vld | (crc != hold_byte).
  - These status outputs hold until the next DONE.
- **CRC-8:**
  - Polynomial x^8+x^2+x+1, seed CRC_INIT.
  - Computed over payload bytes only, byte-parallel, with data bit 7 as the first serial bit.
  - Uses the same nextCRC8D8 equations as the slave transmitter.
- **Zero-payload frame:** a single CRC byte of 0xFF is a valid frame with byte_num 0 and err 0.
- **Reset:**
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-frame abandons the frame with no rx_frame_done_o.
  - Reception resumes only on the next FSX rising edge.

## Timing
- **Byte latency:** the 8th bit of byte k+1 is present at the pins at rising edge t. Payload byte k then appears with rx_data_vld_o = 1 in the cycle after edge t+2.
- **Strobe spacing:** at full line rate, consecutive rx_data_vld_o strobes are exactly 8 cycles apart.
- **Frame-done latency:** msg_fsx_i is first sampled low at edge t. rx_frame_done_o is high in the cycle after edge t+2. rx_byte_num_o, rx_crc_err_o and rx_ovf_o are valid in that same cycle.
- **Back-to-back frames:** FSX may rise again one cycle after it falls. The DONE cycle coincides with IDLE edge detection, so no bits are lost. A DONE and the first bit of the next frame may overlap.
- **Simultaneous events:**
  - FSX falls in the same cycle that a byte completes: that byte counts as complete and becomes the CRC byte.
  - rx_data_vld_o never asserts in the same cycle as rx_frame_done_o.
- **Flow control:** none; the consumer must accept one byte per 8 cycles.

## Test plan
- **Single-byte frame:** FSX high 16 cycles carrying 0x00, 0xF3 -> one rx_data_vld_o with data 0x00, then rx_frame_done_o with byte_num = 1, crc_err = 0, ovf = 0.
- **Zero-payload frame:** FSX high 8 cycles carrying 0xFF -> no rx_data_vld_o; rx_frame_done_o with byte_num = 0, crc_err = 0.
- **Corrupted CRC:** 0x00, 0xF2 -> data 0x00 is emitted; crc_err = 1.
- **Short and partial frames:**
  - FSX high 5 cycles -> frame_done with byte_num = 0, crc_err = 1.
  - 0x00, 0xF3 plus 3 trailing bits -> result identical to the single-byte frame.
- **Overflow:** MAX_BYTES = 4, send 6 payload bytes plus CRC -> exactly 4 strobes; frame_done with byte_num = 4, ovf = 1, crc_err = 1.
- **Reset and back-to-back:**
  - Assert rst_i mid-byte -> no frame_done; FSX held high through reset release is ignored.
  - Two valid frames with a 1-cycle FSX-low gap -> two correct frame_done pulses.
